// File: rtl/n2_dva_upd_ctl_if.sv
// Request/response and array-port bundle for the dirty/valid array controller.
// The controller attaches through the slave modport; pipeline control and array sit on master.
interface n2_dva_upd_ctl_if;
  logic        req_vld;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_addr;
  logic [31:0] req_mask;
  logic [31:0] req_data;
  logic        rsp_vld;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        clr_all;
  logic        clr_all_done;
  logic        arr_rd_en;
  logic [4:0]  arr_rd_addr;
  logic        arr_wr_en;
  logic [4:0]  arr_wr_addr;
  logic [31:0] arr_din;
  logic [31:0] arr_bit_wen;
  logic [31:0] arr_dout;

  modport slave (
    input  req_vld, req_op, req_addr, req_mask, req_data, rsp_ready, clr_all, arr_dout,
    output req_ready, rsp_vld, rsp_data, clr_all_done,
           arr_rd_en, arr_rd_addr, arr_wr_en, arr_wr_addr, arr_din, arr_bit_wen
  );

  modport master (
    output req_vld, req_op, req_addr, req_mask, req_data, rsp_ready, clr_all, arr_dout,
    input  req_ready, rsp_vld, rsp_data, clr_all_done,
           arr_rd_en, arr_rd_addr, arr_wr_en, arr_wr_addr, arr_din, arr_bit_wen
  );
endinterface

// File: rtl/n2_dva_upd_ctl.sv
// Access controller for the 32x32 dirty/valid array: request channel, read response, clear-all sweep.
// state | meaning:  IDLE = service requests / watch clr_all ; SWEEP = zero one entry per cycle
module n2_dva_upd_ctl (
  input  logic            l2clk,
  input  logic            reset,
  n2_dva_upd_ctl_if.slave bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLR   = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b11;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        done_q, done_d;

  logic        wr_ok, rd_ok, req_ready_c, acc;

  always_ff @(posedge l2clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      rd_pend_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= rd_pend_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    rd_pend_d  = acc & (bus.req_op == OP_READ);
    rsp_vld_d  = rsp_vld_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_all) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pending read always lands, even if a sweep started meanwhile; the response slot is free by construction.
    if (rd_pend_q) begin
      rsp_vld_d  = 1'b1;
      rsp_data_d = bus.arr_dout;
    end else if (rsp_vld_q && bus.rsp_ready) begin
      rsp_vld_d  = 1'b0;
    end
  end

  always_comb begin
    wr_ok           = (state_q == ST_IDLE) & ~bus.clr_all & ~reset;
    rd_ok           = wr_ok & ~rd_pend_q & (~rsp_vld_q | bus.rsp_ready);
    req_ready_c     = (bus.req_op == OP_READ) ? rd_ok : wr_ok;
    acc             = bus.req_vld & req_ready_c;
    bus.arr_rd_en   = 1'b0;
    bus.arr_rd_addr = 5'd0;
    bus.arr_wr_en   = 1'b0;
    bus.arr_wr_addr = 5'd0;
    bus.arr_din     = 32'd0;
    bus.arr_bit_wen = 32'd0;
    if (!reset && state_q == ST_SWEEP) begin
      bus.arr_wr_en   = 1'b1;
      bus.arr_wr_addr = cnt_q;
      bus.arr_bit_wen = '1;
    end else if (acc) begin
      case (bus.req_op)
        OP_READ: begin
          bus.arr_rd_en   = 1'b1;
          bus.arr_rd_addr = bus.req_addr;
        end
        OP_SET: begin
          bus.arr_wr_en   = 1'b1;
          bus.arr_wr_addr = bus.req_addr;
          bus.arr_din     = '1;
          bus.arr_bit_wen = bus.req_mask;
        end
        OP_CLR: begin
          bus.arr_wr_en   = 1'b1;
          bus.arr_wr_addr = bus.req_addr;
          bus.arr_bit_wen = bus.req_mask;
        end
        default: begin
          bus.arr_wr_en   = 1'b1;
          bus.arr_wr_addr = bus.req_addr;
          bus.arr_din     = bus.req_data;
          bus.arr_bit_wen = bus.req_mask;
        end
      endcase
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.rsp_vld      = rsp_vld_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.clr_all_done = done_q;

endmodule

// File: tb/tb_n2_dva_upd_ctl.sv
// Bench for n2_dva_upd_ctl: behavioural array macro, reference array and a read-response scoreboard.
module tb_n2_dva_upd_ctl;
  logic l2clk = 1'b0;
  logic reset = 1'b1;
  always #5 l2clk = ~l2clk;

  n2_dva_upd_ctl_if u_if();
  n2_dva_upd_ctl u_dut (.l2clk(l2clk), .reset(reset), .bus(u_if));

  logic [31:0] arr_mem [32] = '{default: 32'h0};
  logic [31:0] ref_mem [32] = '{default: 32'h0};
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  // Array macro: write at the edge, registered read data.
  always @(posedge l2clk) begin
    if (u_if.arr_wr_en)
      arr_mem[u_if.arr_wr_addr] <= (arr_mem[u_if.arr_wr_addr] & ~u_if.arr_bit_wen) |
                                   (u_if.arr_din & u_if.arr_bit_wen);
    if (u_if.arr_rd_en) u_if.arr_dout <= arr_mem[u_if.arr_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge l2clk) begin
    if (!reset) begin
      chk("port_contention", {31'b0, u_if.arr_rd_en & u_if.arr_wr_en}, 32'd0);
      if (u_if.rsp_vld && u_if.rsp_ready) begin
        chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rsp_data", u_if.rsp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge l2clk);
    #2;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [4:0] a, input logic [31:0] m,
                        input logic [31:0] d, input bit rnd);
    int w;
    logic [31:0] de;
    u_if.req_vld  = 1'b1;
    u_if.req_op   = op;
    u_if.req_addr = a;
    u_if.req_mask = m;
    u_if.req_data = d;
    if (rnd) u_if.rsp_ready = ($urandom_range(0, 3) != 0);
    #1;
    w = 0;
    while (!u_if.req_ready && w < 40) begin
      tick();
      if (rnd) u_if.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      w++;
    end
    chk("req_accept", {31'b0, u_if.req_ready}, 32'd1);
    if (u_if.req_ready) begin
      if (op == 2'b00) begin
        chk("rd_en", {31'b0, u_if.arr_rd_en}, 32'd1);
        chk("rd_addr", {27'b0, u_if.arr_rd_addr}, {27'b0, a});
        exp_q.push_back(ref_mem[a]);
      end else begin
        de = (op == 2'b01) ? 32'hFFFF_FFFF : (op == 2'b10) ? 32'h0 : d;
        chk("wr_en", {31'b0, u_if.arr_wr_en}, 32'd1);
        chk("wr_addr", {27'b0, u_if.arr_wr_addr}, {27'b0, a});
        chk("wr_din", u_if.arr_din, de);
        chk("wr_bit_wen", u_if.arr_bit_wen, m);
        ref_mem[a] = (ref_mem[a] & ~m) | (de & m);
      end
    end
    tick();
    u_if.req_vld = 1'b0;
  endtask

  initial begin
    u_if.req_vld   = 1'b0;
    u_if.req_op    = 2'b00;
    u_if.req_addr  = 5'd0;
    u_if.req_mask  = 32'd0;
    u_if.req_data  = 32'd0;
    u_if.rsp_ready = 1'b1;
    u_if.clr_all   = 1'b0;

    // Reset: enables and req_ready held low even with a request presented.
    tick(); tick();
    u_if.req_vld = 1'b1;
    u_if.req_op  = 2'b11;
    #1;
    chk("rst_req_ready", {31'b0, u_if.req_ready}, 32'd0);
    chk("rst_wr_en", {31'b0, u_if.arr_wr_en}, 32'd0);
    chk("rst_rd_en", {31'b0, u_if.arr_rd_en}, 32'd0);
    chk("rst_rsp_vld", {31'b0, u_if.rsp_vld}, 32'd0);
    chk("rst_rsp_data", u_if.rsp_data, 32'd0);
    chk("rst_done", {31'b0, u_if.clr_all_done}, 32'd0);
    tick();
    u_if.req_vld = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst_ready_wr", {31'b0, u_if.req_ready}, 32'd1);
    u_if.req_op = 2'b00;
    #1;
    chk("post_rst_ready_rd", {31'b0, u_if.req_ready}, 32'd1);

    // SET then READ with 2-cycle latency.
    do_req(2'b01, 5'd5, 32'h0000_00FF, 32'h0, 1'b0);
    do_req(2'b00, 5'd5, 32'h0, 32'h0, 1'b0);
    chk("rd_lat_n1", {31'b0, u_if.rsp_vld}, 32'd0);
    tick();
    chk("rd_lat_n2", {31'b0, u_if.rsp_vld}, 32'd1);
    chk("rd_set_data", u_if.rsp_data, 32'h0000_00FF);
    tick();
    chk("rsp_clear", {31'b0, u_if.rsp_vld}, 32'd0);

    // WRITE, CLR, READ on entry 31.
    do_req(2'b11, 5'd31, 32'hFFFF_0000, 32'hA5A5_A5A5, 1'b0);
    do_req(2'b10, 5'd31, 32'h00F0_0000, 32'h0, 1'b0);
    do_req(2'b00, 5'd31, 32'h0, 32'h0, 1'b0);
    tick();
    chk("wr_clr_data", u_if.rsp_data, 32'hA505_0000);
    tick();

    // Back-to-back reads under backpressure.
    do_req(2'b11, 5'd1, 32'hFFFF_FFFF, 32'h1111_1111, 1'b0);
    do_req(2'b11, 5'd2, 32'hFFFF_FFFF, 32'h2222_2222, 1'b0);
    u_if.rsp_ready = 1'b0;
    do_req(2'b00, 5'd1, 32'h0, 32'h0, 1'b0);
    u_if.req_vld  = 1'b1;
    u_if.req_op   = 2'b00;
    u_if.req_addr = 5'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rd2_blocked", {31'b0, u_if.req_ready}, 32'd0);
      tick();
    end
    chk("rd1_held", u_if.rsp_data, 32'h1111_1111);
    u_if.rsp_ready = 1'b1;
    do_req(2'b00, 5'd2, 32'h0, 32'h0, 1'b0);
    tick(); tick();

    // Sweep: concurrent write refused, 32 zeroing writes, done 33 cycles later.
    u_if.clr_all  = 1'b1;
    u_if.req_vld  = 1'b1;
    u_if.req_op   = 2'b11;
    u_if.req_addr = 5'd3;
    u_if.req_mask = 32'hFFFF_FFFF;
    u_if.req_data = 32'h1234_5678;
    #1;
    chk("clr_blocks_req", {31'b0, u_if.req_ready}, 32'd0);
    chk("clr_no_wr", {31'b0, u_if.arr_wr_en}, 32'd0);
    tick();
    u_if.clr_all = 1'b0;
    u_if.req_vld = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("sw_wr_en", {31'b0, u_if.arr_wr_en}, 32'd1);
      chk("sw_addr", {27'b0, u_if.arr_wr_addr}, 32'(i));
      chk("sw_din", u_if.arr_din, 32'd0);
      chk("sw_wen", u_if.arr_bit_wen, 32'hFFFF_FFFF);
      chk("sw_ready", {31'b0, u_if.req_ready}, 32'd0);
      chk("sw_done_early", {31'b0, u_if.clr_all_done}, 32'd0);
      tick();
    end
    chk("sw_done", {31'b0, u_if.clr_all_done}, 32'd1);
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    tick();
    chk("sw_done_pulse", {31'b0, u_if.clr_all_done}, 32'd0);
    do_req(2'b00, 5'd0, 32'h0, 32'h0, 1'b0);
    tick();
    do_req(2'b00, 5'd5, 32'h0, 32'h0, 1'b0);
    tick();
    do_req(2'b00, 5'd31, 32'h0, 32'h0, 1'b0);
    tick(); tick();

    // Reset during sweep at entry 10.
    for (int i = 0; i < 32; i++)
      do_req(2'b11, 5'(i), 32'hFFFF_FFFF, $urandom, 1'b0);
    u_if.clr_all = 1'b1;
    tick();
    u_if.clr_all = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("sw_at_10", {27'b0, u_if.arr_wr_addr}, 32'd10);
    reset = 1'b1;
    #1;
    chk("rst_sw_wr_en", {31'b0, u_if.arr_wr_en}, 32'd0);
    for (int i = 0; i < 10; i++) ref_mem[i] = 32'h0;
    tick();
    reset = 1'b0;
    u_if.req_op = 2'b00;
    #1;
    chk("rst_sw_ready", {31'b0, u_if.req_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      chk("rst_sw_no_done", {31'b0, u_if.clr_all_done}, 32'd0);
      tick();
    end
    do_req(2'b00, 5'd9, 32'h0, 32'h0, 1'b0);
    tick();
    do_req(2'b00, 5'd10, 32'h0, 32'h0, 1'b0);
    tick();
    do_req(2'b00, 5'd31, 32'h0, 32'h0, 1'b0);
    tick(); tick();

    // Random op stream against the reference model.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] m;
      m = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      do_req(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), m, $urandom, 1'b1);
    end
    u_if.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rsp_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/n2_dva_upd_ctl.md
# n2_dva_upd_ctl

Access controller for the 32-entry x 32-bit dirty/valid array. It drives the array's read and write ports from a single valid/ready request channel and returns read data on a response channel with backpressure. It also runs a hardware clear-all sweep that zeroes every entry. It sits between the L2/LSU pipeline control and the array macro.

## Interface
Parameters: none. Widths are fixed at 32 entries x 32 bits.

Ports:
- l2clk  in  1  — sole clock; all state updates on rising edge.
- reset  in  1  — synchronous, active-high reset.
- req_vld  in  1  — request valid.
- req_ready  out  1  — request accepted when req_vld & req_ready.
- req_op  in  2  — 00 READ, 01 SET (mask bits to 1), 10 CLR (mask bits to 0), 11 WRITE (req_data under mask).
- req_addr  in  5  — entry index.
- req_mask  in  32  — per-bit write enable (ignored for READ).
- req_data  in  32  — write data (WRITE only).
- rsp_vld  out  1  — read response valid.
- rsp_ready  in  1  — response consumed when rsp_vld & rsp_ready.
- rsp_data  out  32  — read data.
- clr_all  in  1  — start clear-all sweep (level sampled in IDLE).
- clr_all_done  out  1  — one-cycle pulse when sweep completes.
- arr_rd_en  out  1  — array read enable.
- arr_rd_addr  out  5  — array read address.
- arr_wr_en  out  1  — array write enable.
- arr_wr_addr  out  5  — array write address.
- arr_din  out  32  — array write data.
- arr_bit_wen  out  32  — array per-bit write enable.
- arr_dout  in  32  — array read data, valid the cycle after arr_rd_en.

## Operation
- States: IDLE and SWEEP. Internal flags: rd_pend (read issued last cycle) and a 5-bit sweep counter.
- Reset: state=IDLE, counter=0, rd_pend=0, rsp_vld=0, rsp_data=0, clr_all_done=0.
- Reset forces all array enables to 0 and req_ready=0 during the reset cycle.
- Reset mid-sweep or mid-read aborts the operation; no done pulse and no response are produced.
- Priority in IDLE:
  - If clr_all=1, enter SWEEP next cycle. req_ready=0 that cycle, so a concurrent request is not accepted.
  - Otherwise, service requests.
- Accept conditions:
  - Writes (SET/CLR/WRITE) are accepted when IDLE & !clr_all.
  - READ is accepted when IDLE & !clr_all & !rd_pend & (!rsp_vld | rsp_ready).
  - req_ready reflects the condition for the presented req_op. It must not depend combinationally on req_vld.
- Array drive is combinational from the accepted request, in the same cycle:
  - READ: arr_rd_en=1, arr_rd_addr=req_addr.
  - SET: arr_wr_en=1, arr_din=all ones, arr_bit_wen=req_mask.
  - CLR: arr_wr_en=1, arr_din=0, arr_bit_wen=req_mask.
  - WRITE: arr_wr_en=1, arr_din=req_data, arr_bit_wen=req_mask.
  - A mask of 0 still asserts arr_wr_en; the array is unchanged.
- Read return: the cycle after a READ is issued (rd_pend=1), arr_dout is registered into rsp_data and rsp_vld=1 from the following cycle.
- Response hold: rsp_vld/rsp_data hold until rsp_ready. rsp_vld clears the cycle after the handshake unless a new response loads that same edge.
- SWEEP: each cycle drives arr_wr_en=1, arr_wr_addr=counter, arr_din=0, arr_bit_wen=all ones, then increments the counter.
  - After writing entry 31: counter wraps to 0, clr_all_done=1 for one cycle, state=IDLE.
  - clr_all is ignored during SWEEP. req_ready=0 throughout SWEEP.
  - A read pending when the sweep starts still completes with pre-sweep data.
- Inactive outputs: unused address/data outputs are 0 when the corresponding enable is 0.
- Port contention: arr_rd_en and arr_wr_en are never both 1 in the same cycle.

## Timing
- Write: accepted cycle N → array updated at the end of N. A READ to the same address in cycle N+1 returns the new value.
- Read: accepted cycle N → arr_dout valid in N+1 → rsp_vld=1 in N+2. Latency is 2 cycles.
- Read throughput: at most 1 read per 2 cycles. Writes may be accepted back-to-back, including in the rd_pend cycle.
- Sweep: clr_all seen in IDLE cycle N → writes in cycles N+1..N+32 → clr_all_done=1 in N+33 (state is IDLE then; req_ready may be 1).
- After reset deasserts: req_ready=1 in the first cycle (for writes, and for reads since rsp_vld=0).

## Test plan
- Reset, then SET addr 5 mask 0x0000_00FF, then READ addr 5 → arr_wr_en pulse with din=0xFFFF_FFFF and bit_wen=0xFF; rsp_vld 2 cycles after READ accept with rsp_data=0x0000_00FF (array model initialized to 0).
- WRITE addr 31 data 0xA5A5_A5A5 mask 0xFFFF_0000, then CLR addr 31 mask 0x00F0_0000, then READ → rsp_data=0xA505_0000.
- Back-to-back READs addr 1, 2 with rsp_ready held 0 for 5 cycles → second read not accepted until the first response is consumed; both responses in order with correct data.
- clr_all asserted together with req_vld WRITE → write not accepted; 32 consecutive writes addr 0..31 with bit_wen=0xFFFF_FFFF; clr_all_done one-cycle pulse 33 cycles later; subsequent READs of any entry return 0.
- Reset asserted at sweep entry 10 → sweep stops, no clr_all_done, entries 10..31 retain prior values, req_ready=1 the cycle after reset deasserts.
- Randomized op stream against a reference array model → every read matches; arr_rd_en & arr_wr_en never both high.
